// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM states, memory limit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [15:0] MEM_TOP_DEFAULT = 16'h3000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WRITE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_RESP   = 3'd5
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for
// sub-word stores. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{lane, 3'b000} +: 8];
        half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            F3_W:    load_data = rdata;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merge_data = rdata;
        case (funct3)
            F3_B:    merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H:    merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    merge_data = wdata;
            default: merge_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// RV32 load/store unit with read-modify-write for SB/SH over a word memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int          ADDR_W  = 16,
    parameter logic [15:0] MEM_TOP = MEM_TOP_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic              req_store,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic              dm_we,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_error
);

    lsu_state_t  state;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        f3_ok;
    logic        pre_err;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    always_comb begin
        if (req_store)
            f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                    (req_funct3 == F3_W);
        else
            f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                    (req_funct3 == F3_W) || (req_funct3 == F3_BU) ||
                    (req_funct3 == F3_HU);
        pre_err = (|req_addr[31:16]) || (req_addr[15:0] >= MEM_TOP) || !f3_ok;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
            pre_err = 1'b1;
        if (req_funct3 == F3_W && |req_addr[1:0])
            pre_err = 1'b1;
`endif
    end

    lsu_align u_align (
        .funct3     (f3_q),
        .lane       (lane_q),
        .rdata      (dm_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            f3_q       <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
        end else begin
            dm_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        f3_q       <= req_funct3;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        if (pre_err) begin
                            // Error responses wait one cycle in RESP so
                            // latency matches a normal load.
                            resp_err <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            dm_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (!req_store) begin
                                state <= S_LOAD;
                            end else if (req_funct3 == F3_W) begin
                                dm_wdata <= req_wdata;
                                dm_we    <= 1'b1;
                                state    <= S_WRITE;
                            end else begin
                                state <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    resp_rdata <= load_data;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_WRITE: begin
                    resp_err   <= dm_error;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RMW_RD: begin
                    dm_wdata <= merge_data;
                    dm_we    <= 1'b1;
                    state    <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    resp_err   <= dm_error;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a word-wide async-read memory model.
module tb_lsu_rmw;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic        req_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic [31:0] dm_rdata;
    logic        dm_error;
    logic        inj_err;

    logic [31:0] mem [0:3071];
    int          we_cnt;
    int          n_cmp;
    int          n_bad;

    lsu_rmw dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_store  (req_store),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_we      (dm_we),
        .dm_rdata   (dm_rdata),
        .dm_error   (dm_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rdata = (dm_addr < 16'h3000) ? mem[dm_addr[13:2]] : 32'h0;
    assign dm_error = inj_err;

    always @(posedge clk) begin
        if (dm_we) begin
            we_cnt <= we_cnt + 1;
            if (dm_addr < 16'h3000)
                mem[dm_addr[13:2]] <= dm_wdata;
        end
    end

    task automatic do_req(input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, dm_we} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_flags got rdy/vld/err/we=%b want 1000",
                     {req_ready, resp_valid, resp_err, dm_we});
        end
        n_cmp++;
        if ({resp_rdata, dm_wdata, dm_addr} !== 80'h0) begin
            n_bad++;
            $display("FAIL reset_data got rdata=%h wdata=%h addr=%h want 0",
                     resp_rdata, dm_wdata, dm_addr);
        end
    endtask

    task automatic test_load_byte();
        int lat;
        mem[4] = 32'h8844_22F1;
        do_req(1'b0, 3'b000, 32'h0011, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_rdata !== 32'h0000_0022 || resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_0011 got lat=%0d rdata=%h err=%b want 2 00000022 0",
                     lat, resp_rdata, resp_err);
        end
        take_resp();
        do_req(1'b0, 3'b000, 32'h0010, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_rdata !== 32'hFFFF_FFF1 || resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_0010 got lat=%0d rdata=%h err=%b want 2 fffffff1 0",
                     lat, resp_rdata, resp_err);
        end
        take_resp();
        do_req(1'b0, 3'b100, 32'h0013, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_rdata !== 32'h0000_0088) begin
            n_bad++;
            $display("FAIL lbu_0013 got lat=%0d rdata=%h want 2 00000088",
                     lat, resp_rdata);
        end
        take_resp();
    endtask

    task automatic test_load_half_word();
        int lat;
        do_req(1'b0, 3'b101, 32'h0012, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_rdata !== 32'h0000_8844) begin
            n_bad++;
            $display("FAIL lhu_0012 got lat=%0d rdata=%h want 2 00008844",
                     lat, resp_rdata);
        end
        take_resp();
        do_req(1'b0, 3'b001, 32'h0012, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_rdata !== 32'hFFFF_8844) begin
            n_bad++;
            $display("FAIL lh_0012 got lat=%0d rdata=%h want 2 ffff8844",
                     lat, resp_rdata);
        end
        take_resp();
        do_req(1'b0, 3'b010, 32'h0010, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_rdata !== 32'h8844_22F1) begin
            n_bad++;
            $display("FAIL lw_0010 got lat=%0d rdata=%h want 2 884422f1",
                     lat, resp_rdata);
        end
        take_resp();
    endtask

    task automatic test_store();
        int lat;
        int w0;
        mem[12'hB01] = 32'h1111_1111;
        w0 = we_cnt;
        do_req(1'b1, 3'b000, 32'h2C05, 32'h0000_00AB, lat);
        n_cmp++;
        if (lat !== 3 || (we_cnt - w0) !== 1 || resp_err !== 1'b0 ||
            resp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL sb_2c05 got lat=%0d we=%0d err=%b rdata=%h want 3 1 0 0",
                     lat, we_cnt - w0, resp_err, resp_rdata);
        end
        n_cmp++;
        if (mem[12'hB01] !== 32'h1111_AB11) begin
            n_bad++;
            $display("FAIL sb_word got %h want 1111ab11", mem[12'hB01]);
        end
        take_resp();
        do_req(1'b1, 3'b001, 32'h2C06, 32'h5555_CAFE, lat);
        n_cmp++;
        if (lat !== 3 || mem[12'hB01] !== 32'hCAFE_AB11) begin
            n_bad++;
            $display("FAIL sh_2c06 got lat=%0d word=%h want 3 cafeab11",
                     lat, mem[12'hB01]);
        end
        take_resp();
        w0 = we_cnt;
        do_req(1'b1, 3'b010, 32'h2C08, 32'hDEAD_BEEF, lat);
        n_cmp++;
        if (lat !== 2 || (we_cnt - w0) !== 1 || mem[12'hB02] !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL sw_2c08 got lat=%0d we=%0d word=%h want 2 1 deadbeef",
                     lat, we_cnt - w0, mem[12'hB02]);
        end
        take_resp();
    endtask

    task automatic test_range();
        int lat;
        int w0;
        w0 = we_cnt;
        do_req(1'b1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, lat);
        n_cmp++;
        if (lat !== 2 || we_cnt !== w0 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL sw_3000 got lat=%0d we=%0d err=%b rdata=%h want 2 0 1 0",
                     lat, we_cnt - w0, resp_err, resp_rdata);
        end
        take_resp();
        do_req(1'b1, 3'b010, 32'h0001_0000, 32'hDEAD_BEEF, lat);
        n_cmp++;
        if (lat !== 2 || we_cnt !== w0 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL sw_10000 got lat=%0d we=%0d err=%b rdata=%h want 2 0 1 0",
                     lat, we_cnt - w0, resp_err, resp_rdata);
        end
        take_resp();
        do_req(1'b0, 3'b011, 32'h0010, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL f3_011 got lat=%0d err=%b rdata=%h want 2 1 0",
                     lat, resp_err, resp_rdata);
        end
        take_resp();
        do_req(1'b0, 3'b010, 32'h2FFC, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL lw_2ffc got lat=%0d err=%b want 2 0", lat, resp_err);
        end
        take_resp();
    endtask

    task automatic test_dm_error();
        int lat;
        inj_err = 1'b1;
        do_req(1'b1, 3'b010, 32'h0020, 32'h1234_5678, lat);
        inj_err = 1'b0;
        n_cmp++;
        if (lat !== 2 || resp_err !== 1'b1) begin
            n_bad++;
            $display("FAIL dm_error got lat=%0d err=%b want 2 1", lat, resp_err);
        end
        take_resp();
    endtask

    task automatic test_back_pressure();
        int lat;
        int bad;
        do_req(1'b0, 3'b010, 32'h0010, 32'h0, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h8844_22F1 ||
                req_ready !== 1'b0)
                bad++;
        end
        n_cmp++;
        if (lat !== 2 || bad !== 0) begin
            n_bad++;
            $display("FAIL hold got lat=%0d unstable_cycles=%0d want 2 0", lat, bad);
        end
        take_resp();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL release got rdy=%b vld=%b want 1 0", req_ready, resp_valid);
        end
        do_req(1'b0, 3'b000, 32'h0011, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_rdata !== 32'h0000_0022) begin
            n_bad++;
            $display("FAIL after_hold got lat=%0d rdata=%h want 2 00000022",
                     lat, resp_rdata);
        end
        take_resp();
    endtask

    task automatic test_reset_mid_rmw();
        int w0;
        mem[12'hB04] = 32'h5555_5555;
        w0 = we_cnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h2C12;
        req_wdata  = 32'h0000_1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (we_cnt !== w0 || mem[12'hB04] !== 32'h5555_5555) begin
            n_bad++;
            $display("FAIL rst_rmw got we=%0d word=%h want 0 55555555",
                     we_cnt - w0, mem[12'hB04]);
        end
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dm_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_idle got rdy=%b vld=%b we=%b want 1 0 0",
                     req_ready, resp_valid, dm_we);
        end
    endtask

    task automatic test_misalign();
        int lat;
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b0, 3'b010, 32'h0002, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL mis_lw got lat=%0d err=%b rdata=%h want 2 1 0",
                     lat, resp_err, resp_rdata);
        end
        take_resp();
        do_req(1'b0, 3'b001, 32'h0011, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_err !== 1'b1) begin
            n_bad++;
            $display("FAIL mis_lh got lat=%0d err=%b want 2 1", lat, resp_err);
        end
        take_resp();
`else
        do_req(1'b0, 3'b010, 32'h0012, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_err !== 1'b0 || resp_rdata !== 32'h8844_22F1) begin
            n_bad++;
            $display("FAIL mis_lw got lat=%0d err=%b rdata=%h want 2 0 884422f1",
                     lat, resp_err, resp_rdata);
        end
        take_resp();
        do_req(1'b0, 3'b001, 32'h0011, 32'h0, lat);
        n_cmp++;
        if (lat !== 2 || resp_err !== 1'b0 || resp_rdata !== 32'h0000_22F1) begin
            n_bad++;
            $display("FAIL mis_lh got lat=%0d err=%b rdata=%h want 2 0 000022f1",
                     lat, resp_err, resp_rdata);
        end
        take_resp();
`endif
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        we_cnt     = 0;
        inj_err    = 1'b0;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        for (int i = 0; i < 3072; i++)
            mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        @(negedge clk);
        test_load_byte();
        test_load_half_word();
        test_store();
        test_range();
        test_dm_error();
        test_back_pressure();
        test_reset_mid_rmw();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
